// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory access at a time, drives a single-cycle
// read or write strobe to memory, and returns a held response with tag and error.
module load_store_unit #(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  NByteOp,
  output logic        Unsigned,
  output logic [31:0] addr,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, RESP} state_t;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  state_t      state;
  logic        is_store_q;
  logic        misaligned;
  logic        req_err;
  logic [31:0] wdata_masked;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    misaligned   = 1'b0;
    wdata_masked = req_wdata;
    if (CHECK_ALIGN) begin
      misaligned = ((req_size == SIZE_HALF) && req_addr[0]) ||
                   ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
    end
    case (req_size)
      SIZE_BYTE: wdata_masked = {24'h0, req_wdata[7:0]};
      SIZE_HALF: wdata_masked = {16'h0, req_wdata[15:0]};
      default:   wdata_masked = req_wdata;
    endcase
  end

  assign req_err   = misaligned || (req_size == SIZE_ILL);
  // Gated by rst_n so the pipeline sees "not ready" for the whole reset window.
  assign req_ready = rst_n && (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
      resp_rd    <= '0;
      addr       <= '0;
      write_data <= '0;
      NByteOp    <= SIZE_WORD;
      Unsigned   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr       <= req_addr;
            NByteOp    <= req_size;
            Unsigned   <= req_unsigned;
            write_data <= wdata_masked;
            resp_rd    <= req_rd;
            is_store_q <= req_is_store;
            resp_data  <= '0;
            resp_err   <= req_err;
            if (req_err) begin
              // Rejected accesses never touch memory.
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (req_is_store) begin
              MemWrite <= 1'b1;
              state    <= STORE;
            end else begin
              MemRead <= 1'b1;
              state   <= LOAD;
            end
          end
        end
        LOAD, STORE: begin
          MemRead    <= 1'b0;
          MemWrite   <= 1'b0;
          resp_data  <= is_store_q ? 32'h0 : read_data;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
